// File: rtl/matmul_sequencer_if.sv
// Handshake and address/strobe bundle between the matmul sequencer and its datapath.
// master drives the requests; slave is the sequencer that answers with strobes.
interface matmul_sequencer_if #(
   parameter int XA_W = 5,
   parameter int CA_W = 4,
   parameter int RA_W = 5
) ();
   logic            start_in;
   logic            valid_input;
   logic            cs_n;
   logic            xbuf_we;
   logic [XA_W-1:0] xbuf_addr;
   logic [CA_W-1:0] rom_addr;
   logic            mac_en;
   logic            mac_clr;
   logic            res_we;
   logic            res_re;
   logic [RA_W-1:0] res_addr;
   logic            xload_done;
   logic            ry;
   logic            busy;
   logic            finish;

   modport master (
      output start_in, valid_input, cs_n,
      input  xbuf_we, xbuf_addr, rom_addr, mac_en, mac_clr, res_we, res_re,
             res_addr, xload_done, ry, busy, finish
   );

   modport slave (
      input  start_in, valid_input, cs_n,
      output xbuf_we, xbuf_addr, rom_addr, mac_en, mac_clr, res_we, res_re,
             res_addr, xload_done, ry, busy, finish
   );
endinterface

// File: rtl/matmul_sequencer.sv
// Sequencer for P = A(ROWS x K) * X(K x COLS): X load, MAC compute, result write-back,
// chip-select gated readout. Emits only addresses, enables and strobes.
module matmul_sequencer #(
   parameter int K    = 4,
   parameter int ROWS = 4,
   parameter int COLS = 8,
   parameter int XA_W = 5,
   parameter int CA_W = 4,
   parameter int RA_W = 5
) (
   input logic               clk,
   input logic               rst,
   matmul_sequencer_if.slave bus
);
   localparam int KW = (K    > 1) ? $clog2(K)    : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [KW-1:0]   K_LAST  = KW'(K - 1);
   localparam logic [CW-1:0]   C_LAST  = CW'(COLS - 1);
   localparam logic [RW-1:0]   R_LAST  = RW'(ROWS - 1);
   localparam logic [XA_W-1:0] LD_LAST = XA_W'(K * COLS - 1);
   localparam logic [RA_W-1:0] RD_LAST = RA_W'(ROWS * COLS - 1);

   typedef enum logic [2:0] {IDLE, LOAD, CALC, WRITE, READ, DONE} state_e;

   state_e          state_q;
   logic [XA_W-1:0] ld_cnt_q;
   logic [KW-1:0]   k_q;
   logic [CW-1:0]   c_q;
   logic [RW-1:0]   r_q;
   logic [RA_W-1:0] rd_cnt_q;
   logic            xload_done_q;
   logic            ry_q;

   logic            wr_x;
   logic            rd_res;
   logic [XA_W-1:0] xbuf_addr;
   logic [CA_W-1:0] rom_addr;
   logic [RA_W-1:0] res_addr;

   // Byte writes and result reads follow their qualifiers in the same cycle.
   always_comb begin
      wr_x   = (state_q == LOAD) && bus.valid_input;
      rd_res = (state_q == READ) && !bus.cs_n;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         ld_cnt_q     <= '0;
         k_q          <= '0;
         c_q          <= '0;
         r_q          <= '0;
         rd_cnt_q     <= '0;
         xload_done_q <= 1'b0;
         ry_q         <= 1'b0;
      end else begin
         xload_done_q <= 1'b0;
         ry_q         <= rd_res;
         unique case (state_q)
            IDLE: if (bus.start_in) state_q <= LOAD;
            LOAD: begin
               if (wr_x) begin
                  if (ld_cnt_q == LD_LAST) begin
                     ld_cnt_q     <= '0;
                     xload_done_q <= 1'b1;
                     state_q      <= CALC;
                  end else begin
                     ld_cnt_q <= ld_cnt_q + 1'b1;
                  end
               end
            end
            CALC: begin
               if (k_q == K_LAST) state_q <= WRITE;
               else               k_q     <= k_q + 1'b1;
            end
            WRITE: begin
               k_q <= '0;
               if (c_q == C_LAST) begin
                  c_q <= '0;
                  if (r_q == R_LAST) begin
                     r_q      <= '0;
                     rd_cnt_q <= '0;
                     state_q  <= READ;
                  end else begin
                     r_q     <= r_q + 1'b1;
                     state_q <= CALC;
                  end
               end else begin
                  c_q     <= c_q + 1'b1;
                  state_q <= CALC;
               end
            end
            READ: begin
               if (rd_res) begin
                  if (rd_cnt_q == RD_LAST) begin
                     rd_cnt_q <= '0;
                     state_q  <= DONE;
                  end else begin
                     rd_cnt_q <= rd_cnt_q + 1'b1;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Addresses are pure decodes of the registered counters, so they drop with reset.
   always_comb begin
      xbuf_addr = '0;
      rom_addr  = '0;
      res_addr  = '0;
      unique case (state_q)
         LOAD: xbuf_addr = ld_cnt_q;
         CALC: begin
            xbuf_addr = XA_W'(k_q) * XA_W'(COLS) + XA_W'(c_q);
            rom_addr  = CA_W'(r_q) * CA_W'(K) + CA_W'(k_q);
         end
         WRITE:   res_addr = RA_W'(r_q) * RA_W'(COLS) + RA_W'(c_q);
         READ:    res_addr = rd_cnt_q;
         default: ;
      endcase
   end

   assign bus.xbuf_we    = wr_x;
   assign bus.xbuf_addr  = xbuf_addr;
   assign bus.rom_addr   = rom_addr;
   assign bus.mac_en     = (state_q == CALC);
   assign bus.mac_clr    = (state_q == CALC) && (k_q == '0);
   assign bus.res_we     = (state_q == WRITE);
   assign bus.res_re     = rd_res;
   assign bus.res_addr   = res_addr;
   assign bus.xload_done = xload_done_q;
   assign bus.ry         = ry_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.finish     = (state_q == DONE);
endmodule
